// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush arbitration, cause FSM, stall counters and watchdog for a 5-stage pipeline
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_RS         = 2,
  parameter int CNT_W          = 16,
  parameter int MAX_DATA_STALL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RS*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_RS-1:0]            id_rs_used,
  input  logic                         id_branch_or_jalr,
  input  logic                         id_ex_mem_read,
  input  logic                         ex_reg_write,
  input  logic [REG_ADDR_W-1:0]        ex_rd,
  input  logic                         ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0]        mem_rd,
  input  logic                         ex_branch_taken,
  input  logic                         im_stall,
  input  logic                         dm_stall,
  output logic                         pc_write,
  output logic                         if_id_write,
  output logic                         id_ex_write,
  output logic                         ex_mem_write,
  output logic                         mem_wb_write,
  output logic                         hazard_mux_control,
  output logic                         if_id_flush,
  output logic [1:0]                   hz_state,
  output logic [CNT_W-1:0]             data_stall_cnt,
  output logic [CNT_W-1:0]             mem_stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt,
  output logic                         hazard_err
);
  localparam int CW = $clog2(MAX_DATA_STALL + 2);
  typedef enum logic [1:0] {RUN = 2'd0, DSTALL = 2'd1, FREEZE = 2'd2, FLUSH = 2'd3} state_e;
  state_e state_q, cause_d;
  logic flush_pending_q, hazard_err_q;
  logic [CW-1:0] consec_q;
  logic [CNT_W-1:0] dcnt_q, mcnt_q, fcnt_q;
  logic match_ex, match_mem, data_hz, freeze, do_flush, run_or_flush;
  // Compare every used ID source against EX and MEM destinations; x0 never matches
  always_comb begin
    match_ex = 1'b0;
    match_mem = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      match_ex = match_ex | (id_rs_used[i] && id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd && ex_rd != '0);
      match_mem = match_mem | (id_rs_used[i] && id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == mem_rd && mem_rd != '0);
    end
  end
  assign data_hz = (ex_reg_write && (id_ex_mem_read || id_branch_or_jalr) && match_ex) ||
                   (id_branch_or_jalr && ex_mem_mem_read && match_mem);
  assign freeze = im_stall || dm_stall;
  assign do_flush = !freeze && (ex_branch_taken || flush_pending_q);
  assign cause_d = freeze ? FREEZE : do_flush ? FLUSH : data_hz ? DSTALL : RUN;
  assign run_or_flush = cause_d == RUN || cause_d == FLUSH;
  assign pc_write = rst && run_or_flush;
  assign if_id_write = rst && run_or_flush;
  assign id_ex_write = rst && cause_d != FREEZE;
  assign ex_mem_write = rst && cause_d != FREEZE;
  assign mem_wb_write = rst && cause_d != FREEZE;
  assign hazard_mux_control = rst && (cause_d == RUN || cause_d == FREEZE);
  assign if_id_flush = rst && cause_d == FLUSH;
  assign hz_state = state_q;
  assign data_stall_cnt = dcnt_q;
  assign mem_stall_cnt = mcnt_q;
  assign flush_cnt = fcnt_q;
  assign hazard_err = hazard_err_q;
  // Cause register, redirect held across freezes, saturating counters and data-stall watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      flush_pending_q <= 1'b0;
      hazard_err_q <= 1'b0;
      consec_q <= '0;
      dcnt_q <= '0;
      mcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      state_q <= cause_d;
      flush_pending_q <= !do_flush && (flush_pending_q || (ex_branch_taken && freeze));
      dcnt_q <= dcnt_q + CNT_W'(cause_d == DSTALL && dcnt_q != '1);
      mcnt_q <= mcnt_q + CNT_W'(cause_d == FREEZE && mcnt_q != '1);
      fcnt_q <= fcnt_q + CNT_W'(cause_d == FLUSH && fcnt_q != '1);
      if (cause_d == DSTALL) begin
        if (consec_q == CW'(MAX_DATA_STALL)) hazard_err_q <= 1'b1;
        if (consec_q != '1) consec_q <= consec_q + CW'(1);
      end else if (cause_d != FREEZE) begin
        consec_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] id_rs_addr;
  logic [1:0] id_rs_used;
  logic id_branch_or_jalr, id_ex_mem_read, ex_reg_write, ex_mem_mem_read, ex_branch_taken, im_stall, dm_stall;
  logic [4:0] ex_rd, mem_rd;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, hazard_mux_control, if_id_flush, hazard_err;
  logic [1:0] hz_state;
  logic [15:0] data_stall_cnt, mem_stall_cnt, flush_cnt;
  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_mux, s_flush, s_err;
  logic [1:0] s_state, s_dcnt, s_mcnt, s_fcnt;
  int checks = 0, errors = 0;
  typedef struct {string tag; int sel; int exp;} item_t;
  item_t sb[$];
  localparam int EN_RUN = 'h7E, EN_DST = 'h1C, EN_FRZ = 'h02, EN_FLS = 'h7D, EN_RST = 'h00;
  localparam int S_EN = 0, S_ST = 1, S_DC = 2, S_MC = 3, S_FC = 4, S_ERR = 5, S_SMC = 6;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_branch_or_jalr(id_branch_or_jalr), .id_ex_mem_read(id_ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .mem_rd(mem_rd), .ex_branch_taken(ex_branch_taken),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .hazard_mux_control(hazard_mux_control), .if_id_flush(if_id_flush), .hz_state(hz_state),
    .data_stall_cnt(data_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt),
    .hazard_err(hazard_err));

  hazard_ctrl_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_branch_or_jalr(id_branch_or_jalr), .id_ex_mem_read(id_ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_mem_mem_read(ex_mem_mem_read), .mem_rd(mem_rd), .ex_branch_taken(ex_branch_taken),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(s_pc), .if_id_write(s_ifid),
    .id_ex_write(s_idex), .ex_mem_write(s_exmem), .mem_wb_write(s_memwb),
    .hazard_mux_control(s_mux), .if_id_flush(s_flush), .hz_state(s_state),
    .data_stall_cnt(s_dcnt), .mem_stall_cnt(s_mcnt), .flush_cnt(s_fcnt), .hazard_err(s_err));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      S_EN:    return int'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, hazard_mux_control, if_id_flush});
      S_ST:    return int'(hz_state);
      S_DC:    return int'(data_stall_cnt);
      S_MC:    return int'(mem_stall_cnt);
      S_FC:    return int'(flush_cnt);
      S_ERR:   return int'(hazard_err);
      default: return int'(s_mcnt);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.tag, observe(it.sel), it.exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs_addr = '0; id_rs_used = '0; id_branch_or_jalr = 0; id_ex_mem_read = 0; ex_reg_write = 0;
    ex_rd = '0; ex_mem_mem_read = 0; mem_rd = '0; ex_branch_taken = 0; im_stall = 0; dm_stall = 0;
  endtask

  task automatic load_use(input logic [4:0] r);
    id_ex_mem_read = 1; ex_reg_write = 1; ex_rd = r; id_rs_addr = {5'd0, r}; id_rs_used = 2'b01;
  endtask

  initial begin
    rst = 0;
    clr();
    @(posedge clk); #1;
    push("rst_en", S_EN, EN_RST); push("rst_state", S_ST, 0); push("rst_dcnt", S_DC, 0);
    tick();
    rst = 1;
    push("idle_en", S_EN, EN_RUN); push("idle_err", S_ERR, 0);
    tick();
    load_use(5'd5);
    push("lu_en", S_EN, EN_DST);
    tick();
    clr();
    push("lu_after_en", S_EN, EN_RUN); push("lu_state", S_ST, 1); push("lu_dcnt", S_DC, 1);
    tick();
    load_use(5'd0);
    push("x0_en", S_EN, EN_RUN);
    tick();
    ex_rd = 5'd7; id_rs_addr = {5'd7, 5'd1}; id_rs_used = 2'b01;
    push("mask_en", S_EN, EN_RUN); push("mask_state", S_ST, 0);
    tick();
    clr();
    id_branch_or_jalr = 1; id_ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd3;
    id_rs_addr = {5'd3, 5'd1}; id_rs_used = 2'b11;
    push("lb_a_en", S_EN, EN_DST); push("lb_a_state", S_ST, 0); push("lb_a_dcnt", S_DC, 1);
    tick();
    id_ex_mem_read = 0; ex_reg_write = 0; ex_mem_mem_read = 1; mem_rd = 5'd3;
    push("lb_b_en", S_EN, EN_DST); push("lb_b_state", S_ST, 1); push("lb_b_err", S_ERR, 0);
    tick();
    push("lb_c_en", S_EN, EN_DST); push("lb_c_err", S_ERR, 0); push("lb_c_dcnt", S_DC, 3);
    tick();
    clr();
    push("wd_err", S_ERR, 1); push("wd_dcnt", S_DC, 4); push("wd_en", S_EN, EN_RUN);
    tick();
    push("wd_sticky", S_ERR, 1); push("wd_state", S_ST, 0);
    tick();
    dm_stall = 1; ex_branch_taken = 1;
    push("frz1_en", S_EN, EN_FRZ); push("frz1_mcnt", S_MC, 0);
    tick();
    ex_branch_taken = 0;
    push("frz2_en", S_EN, EN_FRZ); push("frz2_state", S_ST, 2); push("frz2_mcnt", S_MC, 1);
    tick();
    push("frz3_en", S_EN, EN_FRZ);
    tick();
    push("frz4_en", S_EN, EN_FRZ);
    tick();
    dm_stall = 0;
    push("pend_en", S_EN, EN_FLS); push("pend_mcnt", S_MC, 4); push("pend_fcnt", S_FC, 0);
    tick();
    push("pend_after_en", S_EN, EN_RUN); push("pend_state", S_ST, 3); push("pend_fcnt1", S_FC, 1);
    tick();
    load_use(5'd5); ex_branch_taken = 1;
    push("prio_en", S_EN, EN_FLS); push("prio_dcnt", S_DC, 4);
    tick();
    clr();
    push("prio_after_dcnt", S_DC, 4); push("prio_fcnt", S_FC, 2); push("prio_state", S_ST, 3);
    tick();
    load_use(5'd5); im_stall = 1;
    push("fz_hz_en", S_EN, EN_FRZ);
    tick();
    im_stall = 0;
    push("fz_hz_after_en", S_EN, EN_DST); push("fz_hz_state", S_ST, 2); push("fz_hz_mcnt", S_MC, 5);
    tick();
    im_stall = 1;
    push("mid_en", S_EN, EN_FRZ); push("mid_dcnt", S_DC, 5); push("sat_mcnt", S_SMC, 3);
    tick();
    #2 rst = 0;
    #1;
    push("arst_en", S_EN, EN_RST); push("arst_dcnt", S_DC, 0); push("arst_mcnt", S_MC, 0);
    push("arst_fcnt", S_FC, 0); push("arst_err", S_ERR, 0); push("arst_state", S_ST, 0); push("arst_smcnt", S_SMC, 0);
    drain();
    @(posedge clk); #1;
    clr();
    rst = 1;
    push("rel_en", S_EN, EN_RUN); push("rel_state", S_ST, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the CPU hazard detection logic for the 5-stage RISC-V pipeline with AXI-attached instruction and data memories. It arbitrates three stall/flush causes per cycle, in this priority order:
- memory freeze, from AXI wait on IM or DM
- branch/jalr flush
- data hazard, covering load-use and branch-operand dependencies

It drives per-stage pipeline-register write enables, the control-bubble mux and the IF/ID flush. It also keeps a cause FSM, saturating per-cause stall counters and a stall watchdog.

Parameters:
REG_ADDR_W, 5, register address width (4 for RV32E)
NUM_RS, 2, source operands checked per ID instruction (3 for R4-type)
CNT_W, 16, width of each saturating event counter
MAX_DATA_STALL, 2, max legal consecutive data-stall cycles before hazard_err

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_rs_addr  in  NUM_RS*REG_ADDR_W  ID source regs, rs[i] at bits [i*REG_ADDR_W +: REG_ADDR_W]
id_rs_used  in  NUM_RS  per-source valid mask (I-type clears rs2)
id_branch_or_jalr  in  1  ID instruction resolves branch/jalr in ID
id_ex_mem_read  in  1  EX-stage instruction is a load
ex_reg_write  in  1  EX-stage instruction writes rd
ex_rd  in  REG_ADDR_W  EX-stage rd
ex_mem_mem_read  in  1  MEM-stage instruction is a load
mem_rd  in  REG_ADDR_W  MEM-stage rd
ex_branch_taken  in  1  redirect resolved this cycle
im_stall  in  1  AXI instruction fetch pending
dm_stall  in  1  AXI data access pending
pc_write  out  1  PC enable
if_id_write  out  1  IF/ID enable
id_ex_write  out  1  ID/EX enable
ex_mem_write  out  1  EX/MEM enable
mem_wb_write  out  1  MEM/WB enable
hazard_mux_control  out  1  1 = pass ID control, 0 = insert bubble
if_id_flush  out  1  clear IF/ID
hz_state  out  2  registered cause of previous cycle
data_stall_cnt  out  CNT_W  data-stall cycles
mem_stall_cnt  out  CNT_W  freeze cycles
flush_cnt  out  CNT_W  flushes issued
hazard_err  out  1  sticky watchdog flag

Behaviour:
- match(r) = OR over i of (id_rs_used[i] && rs[i] == r && r != 0). x0 never creates a hazard.
- hzA = ex_reg_write && (id_ex_mem_read || id_branch_or_jalr) && match(ex_rd)
- hzB = id_branch_or_jalr && ex_mem_mem_read && match(mem_rd)
- data_hz = hzA || hzB
- freeze = im_stall || dm_stall
- do_flush = !freeze && (ex_branch_taken || flush_pending)
- Outputs are combinational from inputs plus state. Per-cycle priority:
  - freeze: all five write enables 0; hazard_mux_control 1; if_id_flush 0.
  - do_flush: all write enables 1; if_id_flush 1; hazard_mux_control 0 (squash wrong-path ID). data_hz is ignored.
  - data_hz: pc_write 0; if_id_write 0; id_ex/ex_mem/mem_wb_write 1; hazard_mux_control 0.
  - otherwise: all write enables 1; hazard_mux_control 1; if_id_flush 0.
- flush_pending register:
  - set when ex_branch_taken && freeze
  - cleared in the cycle do_flush is asserted
  - a redirect arriving during an AXI freeze is never lost
- FSM, registered on rising clk:
  - states RUN=0, DSTALL=1, FREEZE=2, FLUSH=3.
  - next state = cause of the current cycle under the priority above.
  - hz_state shows the state register.
- Counters, all saturating at 2^CNT_W-1, no wrap:
  - data_stall_cnt +1 per DSTALL cycle
  - mem_stall_cnt +1 per FREEZE cycle
  - flush_cnt +1 per cycle with if_id_flush = 1
- Watchdog:
  - consec counter, ceil(log2(MAX_DATA_STALL+2)) bits, +1 per DSTALL cycle.
  - holds during FREEZE; clears on RUN or FLUSH.
  - a DSTALL cycle with consec == MAX_DATA_STALL sets hazard_err, which is sticky until reset.
  - legal worst case: load followed by dependent branch, giving hzA then hzB = 2 cycles.
- Reset (rst = 0, asynchronous):
  - state RUN; counters, consec, flush_pending and hazard_err all 0.
  - while rst = 0 outputs are forced: all write enables 0, hazard_mux_control 0, if_id_flush 0.
  - the first cycle after release evaluates normally.
- Simultaneous freeze + data_hz: freeze wins; data_hz is re-evaluated after the freeze with unchanged stage contents.

Test Plan:
- Load-use: id_ex_mem_read=1, ex_reg_write=1, ex_rd=5, rs1=5, used=01 -> pc_write=0, if_id_write=0, hazard_mux_control=0, id_ex_write=1 for 1 cycle; data_stall_cnt=1.
- x0/mask: ex_rd=0 matching rs1=0, then ex_rd=7 with rs2=7 and used=01 -> no stall; hz_state stays RUN.
- Load then branch, rd=3 = branch rs2: 2 consecutive DSTALL cycles; hazard_err stays 0. Holding hzB for a 3rd cycle -> hazard_err=1, and it stays 1.
- Freeze with redirect: dm_stall=1 for 4 cycles with ex_branch_taken pulsed in cycle 1 -> all enables 0 for 4 cycles, mem_stall_cnt=4; if_id_flush=1 in cycle 5, flush_cnt=1.
- Priority: ex_branch_taken=1 together with hzA -> if_id_flush=1, pc_write=1, hazard_mux_control=0; data_stall_cnt unchanged.
- Saturation/reset: CNT_W=2 with 5 freeze cycles -> mem_stall_cnt=3. Async rst drop mid-stall -> counters 0 and all enables 0 immediately.
